// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding and the
// default reset PC.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder (4-bit groups, group lookahead on top).
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    // Group-level carries
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & gc[0]);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & gc[0]);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & gc[0]);

    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;
        assign gp[k]  = &p[B+3:B];
        assign gg[k]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign c[B]   = gc[k];
        assign c[B+1] = g[B] | (p[B] & gc[k]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[k]);
    end

    assign sum  = p ^ c;
    assign cout = gc[4];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential reads to instruction memory,
// presents one registered instruction to decode, and handles stall, redirect
// and halt. A request that has been issued without completing is always
// carried to completion (DRAIN) before the address changes.
// Optional build macro FETCH_MISS_CNT_EN adds the miss_cycles counter port.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
`ifdef FETCH_MISS_CNT_EN
    output logic [15:0] miss_cycles,
`endif
    output logic        halted
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  pc_inc;
    logic [15:0]  pend_pc;
    logic [15:0]  buf_instr;
    logic [15:0]  buf_pc;
    logic         pending;
    logic         halt_pend;
    logic         xfer;
    logic         miss;
    logic [15:0]  drain_pc;
    logic         drain_halt;
    logic         unused_cout;

    cla_16bit u_pc_inc (
        .a    (pc),
        .b    (16'h0002),
        .cin  (1'b0),
        .sum  (pc_inc),
        .cout (unused_cout)
    );

    // Request generation: HOLD and HALT never request, DRAIN keeps its request up
    always_comb begin
        imem_req = 1'b0;
        case (state)
            ST_FETCH: imem_req = !stall || pending;
            ST_DRAIN: imem_req = 1'b1;
            default:  imem_req = 1'b0;
        endcase
    end

    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);
    assign xfer      = imem_req && imem_valid;
    // A request that goes unanswered this cycle is in flight and must be drained
    assign miss      = imem_req && !imem_valid;

    // Where a drain finishes: a redirect seen during the drain replaces the target and cancels a halt
    always_comb begin
        drain_pc   = redirect ? redirect_pc : pend_pc;
        drain_halt = redirect ? 1'b0 : (halt || halt_pend);
    end

    // Fetch state machine and decode-side output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            pending     <= 1'b0;
            halt_pend   <= 1'b0;
            pend_pc     <= 16'h0000;
            buf_instr   <= 16'h0000;
            buf_pc      <= 16'h0000;
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
            pc_plus2    <= 16'h0000;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (redirect) begin
                        instr_valid <= 1'b0;
                        if (miss) begin
                            pend_pc   <= redirect_pc;
                            halt_pend <= 1'b0;
                            pending   <= 1'b1;
                            state     <= ST_DRAIN;
                        end else begin
                            pc      <= redirect_pc;
                            pending <= 1'b0;
                        end
                    end else if (halt) begin
                        instr_valid <= 1'b0;
                        if (miss) begin
                            pend_pc   <= pc;
                            halt_pend <= 1'b1;
                            pending   <= 1'b1;
                            state     <= ST_DRAIN;
                        end else begin
                            pending <= 1'b0;
                            state   <= ST_HALT;
                        end
                    end else if (xfer) begin
                        pending <= 1'b0;
                        pc      <= pc_inc;
                        if (stall) begin
                            buf_instr <= imem_data;
                            buf_pc    <= pc;
                            state     <= ST_HOLD;
                        end else begin
                            instr       <= imem_data;
                            instr_pc    <= pc;
                            pc_plus2    <= pc_inc;
                            instr_valid <= 1'b1;
                        end
                    end else begin
                        pending <= imem_req;
                        if (!stall) begin
                            instr_valid <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc          <= redirect_pc;
                        instr_valid <= 1'b0;
                        state       <= ST_FETCH;
                    end else if (halt) begin
                        instr_valid <= 1'b0;
                        state       <= ST_HALT;
                    end else if (!stall) begin
                        // pc already advanced past the buffered word, so it is that word's pc+2
                        instr       <= buf_instr;
                        instr_pc    <= buf_pc;
                        pc_plus2    <= pc;
                        instr_valid <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (xfer) begin
                        pending   <= 1'b0;
                        halt_pend <= 1'b0;
                        if (drain_halt) begin
                            state <= ST_HALT;
                        end else begin
                            pc    <= drain_pc;
                            state <= ST_FETCH;
                        end
                    end else begin
                        pend_pc   <= drain_pc;
                        halt_pend <= drain_halt;
                    end
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

`ifdef FETCH_MISS_CNT_EN
    // Saturating count of cycles spent waiting on instruction memory
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cycles <= 16'h0000;
        end else if (miss && (miss_cycles != 16'hFFFF)) begin
            miss_cycles <= miss_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic, compared against a transaction-level model of the fetch rules.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int MD_RUN   = 0;
    localparam int MD_HOLD  = 1;
    localparam int MD_DRAIN = 2;
    localparam int MD_HALT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halted;
`ifdef FETCH_MISS_CNT_EN
    logic [15:0] miss_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state (what memory and decode should observe)
    int          m_mode;
    logic        m_pending;
    logic        m_dhalt;
    logic        m_valid;
    logic [15:0] m_fetch_pc;
    logic [15:0] m_target;
    logic [15:0] m_buf_d;
    logic [15:0] m_buf_a;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic [15:0] m_p2;
    int          m_miss;

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    assign imem_data = imem_valid ? memf(imem_addr) : 16'hDEAD;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_plus2    (pc_plus2),
        .instr_valid (instr_valid),
`ifdef FETCH_MISS_CNT_EN
        .miss_cycles (miss_cycles),
`endif
        .halted      (halted)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; halt = 1'b0; stall = 1'b0;
        imem_valid = 1'b0; redirect_pc = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_mode = MD_RUN; m_pending = 1'b0; m_dhalt = 1'b0; m_valid = 1'b0;
        m_fetch_pc = RESET_PC; m_target = 16'h0000; m_buf_d = 16'h0000; m_buf_a = 16'h0000;
        m_instr = 16'h0000; m_ipc = 16'h0000; m_p2 = 16'h0000; m_miss = 0;
    endtask

    // One clock of stimulus; called at a negedge, returns at the next negedge
    task automatic cycle(input logic r, input logic [15:0] rpc, input logic h,
                         input logic s, input logic v);
        logic req_e, xfer, miss;
        redirect = r; redirect_pc = rpc; halt = h; stall = s; imem_valid = v;
        #1;
        if (m_mode == MD_HALT || m_mode == MD_HOLD) req_e = 1'b0;
        else if (m_mode == MD_DRAIN)                req_e = 1'b1;
        else                                        req_e = !s || m_pending;
        checks++;
        if (imem_req !== req_e) begin
            errors++;
            $display("FAIL imem_req: got %b expected %b (t=%0t)", imem_req, req_e, $time);
        end
        if (req_e) begin
            checks++;
            if (imem_addr !== m_fetch_pc) begin
                errors++;
                $display("FAIL imem_addr: got %h expected %h (t=%0t)", imem_addr, m_fetch_pc, $time);
            end
        end
        xfer = req_e && v;
        miss = req_e && !v;
        if (miss && m_miss < 65535) m_miss++;

        if (m_mode != MD_HALT) begin
            if (r) begin
                m_valid = 1'b0;
                if (m_mode == MD_HOLD) begin
                    m_fetch_pc = rpc; m_mode = MD_RUN;
                end else if (miss) begin
                    m_mode = MD_DRAIN; m_target = rpc; m_dhalt = 1'b0; m_pending = 1'b1;
                end else begin
                    m_fetch_pc = rpc; m_mode = MD_RUN; m_pending = 1'b0; m_dhalt = 1'b0;
                end
            end else if (h) begin
                m_valid = 1'b0;
                if (m_mode == MD_DRAIN) begin
                    if (xfer) m_mode = MD_HALT;
                    else      m_dhalt = 1'b1;
                end else if (m_mode == MD_HOLD) begin
                    m_mode = MD_HALT;
                end else if (miss) begin
                    m_mode = MD_DRAIN; m_dhalt = 1'b1; m_pending = 1'b1;
                end else begin
                    m_mode = MD_HALT;
                end
            end else if (m_mode == MD_DRAIN) begin
                if (xfer) begin
                    m_pending = 1'b0;
                    if (m_dhalt) m_mode = MD_HALT;
                    else begin m_fetch_pc = m_target; m_mode = MD_RUN; end
                end
            end else if (m_mode == MD_HOLD) begin
                if (!s) begin
                    m_valid = 1'b1; m_instr = m_buf_d; m_ipc = m_buf_a;
                    m_p2 = m_buf_a + 16'd2; m_mode = MD_RUN;
                end
            end else begin
                if (xfer) begin
                    if (s) begin
                        m_buf_d = memf(m_fetch_pc); m_buf_a = m_fetch_pc; m_mode = MD_HOLD;
                    end else begin
                        m_valid = 1'b1; m_instr = memf(m_fetch_pc); m_ipc = m_fetch_pc;
                        m_p2 = m_fetch_pc + 16'd2;
                    end
                    m_fetch_pc = m_fetch_pc + 16'd2;
                    m_pending = 1'b0;
                end else begin
                    m_pending = miss;
                    if (!s) m_valid = 1'b0;
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        checks++;
        if (instr_valid !== m_valid) begin
            errors++;
            $display("FAIL instr_valid: got %b expected %b (t=%0t)", instr_valid, m_valid, $time);
        end
        checks++;
        if (halted !== (m_mode == MD_HALT)) begin
            errors++;
            $display("FAIL halted: got %b expected %b (t=%0t)", halted, (m_mode == MD_HALT), $time);
        end
        if (m_valid) begin
            checks++;
            if (instr_pc !== m_ipc || instr !== m_instr || pc_plus2 !== m_p2) begin
                errors++;
                $display("FAIL instr_out: got pc=%h instr=%h p2=%h expected pc=%h instr=%h p2=%h (t=%0t)",
                         instr_pc, instr, pc_plus2, m_ipc, m_instr, m_p2, $time);
            end
        end
`ifdef FETCH_MISS_CNT_EN
        checks++;
        if (miss_cycles !== 16'(m_miss)) begin
            errors++;
            $display("FAIL miss_cycles: got %0d expected %0d", miss_cycles, m_miss);
        end
`endif
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (instr_valid !== 1'b0 || halted !== 1'b0 || instr !== 16'h0000 ||
            instr_pc !== 16'h0000 || pc_plus2 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b h=%b i=%h pc=%h p2=%h expected all zero",
                     instr_valid, halted, instr, instr_pc, pc_plus2);
        end
        checks++;
        if (imem_addr !== RESET_PC || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
`ifdef FETCH_MISS_CNT_EN
        checks++;
        if (miss_cycles !== 16'h0000) begin
            errors++;
            $display("FAIL reset_miss: got %h expected 0000", miss_cycles);
        end
`endif
    endtask

    task automatic test_zero_wait();
        logic [15:0] exp_pc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
            exp_pc = 16'(2 * i);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin
                errors++;
                $display("FAIL zero_wait: got v=%b pc=%h expected v=1 pc=%h", instr_valid, instr_pc, exp_pc);
            end
        end
    endtask

    task automatic test_miss();
        logic [15:0] m0;
        do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
`ifdef FETCH_MISS_CNT_EN
        m0 = miss_cycles;
`else
        m0 = 16'h0000;
`endif
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_addr !== 16'h0004) begin
                errors++;
                $display("FAIL miss_addr: got %h expected 0004", imem_addr);
            end
            cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL miss_bubble: got %b expected 0", instr_valid);
            end
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0004) begin
            errors++;
            $display("FAIL miss_done: got v=%b pc=%h expected v=1 pc=0004", instr_valid, instr_pc);
        end
`ifdef FETCH_MISS_CNT_EN
        checks++;
        if (miss_cycles - m0 !== 16'd3) begin
            errors++;
            $display("FAIL miss_count: got %0d expected 3", miss_cycles - m0);
        end
`else
        if (m0 != 16'h0000) $display("note: unexpected baseline");
`endif
    endtask

    task automatic test_redirect_miss();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0008) begin
            errors++;
            $display("FAIL redir_drain: got v=%b addr=%h expected v=0 addr=0008", instr_valid, imem_addr);
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL redir_target: got v=%b addr=%h expected v=0 addr=0100", instr_valid, imem_addr);
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0100) begin
            errors++;
            $display("FAIL redir_first: got v=%b pc=%h expected v=1 pc=0100", instr_valid, instr_pc);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (instr_pc !== 16'h0008 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_frozen: got pc=%h req=%b expected pc=0008 req=0", instr_pc, imem_req);
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h000A || pc_plus2 !== 16'h000C) begin
            errors++;
            $display("FAIL stall_release: got v=%b pc=%h p2=%h expected v=1 pc=000a p2=000c",
                     instr_valid, instr_pc, pc_plus2);
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (instr_pc !== 16'h000C) begin
            errors++;
            $display("FAIL stall_next: got %h expected 000c", instr_pc);
        end
    endtask

    task automatic test_halt();
        do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 16'h0200, 1'b1, 1'b0, 1'b1);
        checks++;
        if (halted !== 1'b0 || imem_addr !== 16'h0200) begin
            errors++;
            $display("FAIL halt_redirect_wins: got halted=%b addr=%h expected 0 0200", halted, imem_addr);
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_enter: got %b expected 1", halted);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
            checks++;
            if (imem_req !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_stays: got req=%b halted=%b v=%b expected 0 1 0", imem_req, halted, instr_valid);
            end
        end
        do_reset();
        checks++;
        if (halted !== 1'b0 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL halt_reset: got halted=%b addr=%h expected 0 %h", halted, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (instr_pc !== 16'hFFFE || pc_plus2 !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_p2: got pc=%h p2=%h expected fffe 0000", instr_pc, pc_plus2);
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (instr_pc !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_next: got %h expected 0000", instr_pc);
        end
    endtask

    task automatic test_random();
        int halted_for;
        halted_for = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_mode == MD_HALT) halted_for++;
            if (halted_for > 4) begin
                do_reset();
                halted_for = 0;
            end
            cycle(($urandom_range(11) == 0), 16'($urandom), ($urandom_range(63) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(9) < 6));
        end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
        halt = 1'b0; stall = 1'b0; imem_valid = 1'b0;
        test_reset();
        test_zero_wait();
        test_miss();
        test_redirect_miss();
        test_stall_hold();
        test_halt();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
